// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving every strobe of the 8-bit datapath.
// Define CU_STEP_EN to add the Step input (one instruction per Step pulse); otherwise free-running.
module control_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
`ifdef CU_STEP_EN
    input  logic             Step,
`endif
    input  logic [WIDTH-1:0] IROM_dataIn,
    input  logic             zFlag,
    output logic [15:0]      wEN,
    output logic [5:0]       INC,
    output logic [4:0]       RST,
    output logic [2:0]       compMUX,
    output logic [2:0]       aluOP,
    output logic [3:0]       busMUX,
    output logic             selAR,
    output logic             memREAD,
    output logic             memWRITE,
    output logic             iROMREAD,
    output logic             halted,
    output logic             illegal
);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDAC  = 4'h1;
    localparam logic [3:0] OP_STAC  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_LDAR  = 4'h7;
    localparam logic [3:0] OP_JMPZ  = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_INC   = 4'hA;
    localparam logic [3:0] OP_CLR   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;

    localparam logic [3:0] BUS_MEM = 4'd0;
    localparam logic [3:0] BUS_DR  = 4'd2;
    localparam logic [3:0] BUS_AC  = 4'd14;

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC1 = 3'd3,
        S_EXEC2 = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic             illegal_q, illegal_d;

    logic [3:0]  opc;
    logic [3:0]  opr;
    logic        fetch_go;
    logic        bad_instr;
    logic [15:0] stac_mask;
    logic [5:0]  inc_mask;
    logic [4:0]  clr_mask;
    logic [2:0]  cmp_sel;

    assign opc = ir_q[7:4];
    assign opr = ir_q[3:0];

`ifdef CU_STEP_EN
    assign fetch_go = Step;
`else
    assign fetch_go = 1'b1;
`endif

    // Operand-to-strobe maps; an all-zero mask marks an operand the opcode cannot use.
    always_comb begin
        stac_mask = '0;
        inc_mask  = '0;
        clr_mask  = '0;
        cmp_sel   = '0;
        case (opr)
            4'd2:    stac_mask[12] = 1'b1;
            4'd3:    stac_mask[11] = 1'b1;
            4'd4:    stac_mask[10] = 1'b1;
            4'd5:    stac_mask[9]  = 1'b1;
            4'd6:    stac_mask[8]  = 1'b1;
            4'd7:    stac_mask[7]  = 1'b1;
            4'd11:   stac_mask[3]  = 1'b1;
            4'd12:   stac_mask[2]  = 1'b1;
            4'd13:   stac_mask[1]  = 1'b1;
            default: stac_mask     = '0;
        endcase
        case (opr)
            4'd8:    inc_mask[4] = 1'b1;
            4'd9:    inc_mask[3] = 1'b1;
            4'd10:   inc_mask[2] = 1'b1;
            4'd12:   inc_mask[1] = 1'b1;
            4'd13:   inc_mask[0] = 1'b1;
            default: inc_mask    = '0;
        endcase
        case (opr)
            4'd8:    clr_mask[4] = 1'b1;
            4'd9:    clr_mask[3] = 1'b1;
            4'd10:   clr_mask[2] = 1'b1;
            default: clr_mask    = '0;
        endcase
        case (opr[1:0])
            2'd0:    cmp_sel = 3'b001;
            2'd1:    cmp_sel = 3'b010;
            2'd2:    cmp_sel = 3'b100;
            default: cmp_sel = 3'b000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        bad_instr = 1'b0;
        wEN       = '0;
        INC       = '0;
        RST       = '0;
        compMUX   = '0;
        aluOP     = ALU_PASS;
        busMUX    = BUS_MEM;
        selAR     = 1'b0;
        memREAD   = 1'b0;
        memWRITE  = 1'b0;
        iROMREAD  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                iROMREAD = fetch_go;
                if (fetch_go) state_d = S_LATCH;
            end
            S_LATCH: begin
                ir_d    = IROM_dataIn;
                INC[5]  = 1'b1;
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                state_d = S_FETCH;
                case (opc)
                    OP_NOP: ;
                    OP_LDAC: begin
                        busMUX = opr;
                        wEN[0] = 1'b1;
                    end
                    OP_STAC: begin
                        if (stac_mask == '0) begin
                            bad_instr = 1'b1;
                        end else begin
                            busMUX = BUS_AC;
                            wEN    = stac_mask;
                        end
                    end
                    OP_ADD, OP_MUL: begin
                        busMUX = opr;
                        aluOP  = (opc == OP_ADD) ? ALU_ADD : ALU_MUL;
                        wEN[0] = 1'b1;
                    end
                    OP_LOAD: begin
                        memREAD = 1'b1;
                        state_d = S_EXEC2;
                    end
                    OP_STORE: begin
                        memWRITE = 1'b1;
                        busMUX   = BUS_DR;
                    end
                    OP_LDAR: begin
                        iROMREAD = 1'b1;
                        state_d  = S_EXEC2;
                    end
                    OP_JMPZ: begin
                        if (cmp_sel == '0) begin
                            bad_instr = 1'b1;
                        end else begin
                            compMUX = cmp_sel;
                            wEN[15] = zFlag;
                        end
                    end
                    OP_JMP: wEN[15] = 1'b1;
                    OP_INC: begin
                        if (inc_mask == '0) bad_instr = 1'b1;
                        else                INC       = inc_mask;
                    end
                    OP_CLR: begin
                        if (clr_mask == '0) bad_instr = 1'b1;
                        else                RST       = clr_mask;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: bad_instr = 1'b1;
                endcase
            end
            S_EXEC2: begin
                state_d = S_FETCH;
                if (opc == OP_LOAD) begin
                    memREAD = 1'b1;
                    busMUX  = BUS_MEM;
                    wEN[12] = 1'b1;
                end else begin
                    selAR   = 1'b1;
                    wEN[13] = 1'b1;
                    INC[5]  = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_BOOT;
        endcase
        illegal_d = illegal_q | bad_instr;
        illegal   = illegal_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_BOOT;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit: per-cycle strobe vectors versus an instruction-level model.
module tb_control_unit;

    typedef struct packed {
        logic [15:0] wen;
        logic [5:0]  inc;
        logic [4:0]  rst;
        logic [2:0]  cmp;
        logic [2:0]  alu;
        logic [3:0]  bus;
        logic        sel_ar;
        logic        mrd;
        logic        mwr;
        logic        ird;
        logic        halted;
        logic        illegal;
    } outs_t;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [7:0]  IROM_dataIn = 8'h00;
    logic        zFlag = 1'b0;
    logic [15:0] wEN;
    logic [5:0]  INC;
    logic [4:0]  RST;
    logic [2:0]  compMUX;
    logic [2:0]  aluOP;
    logic [3:0]  busMUX;
    logic        selAR, memREAD, memWRITE, iROMREAD, halted, illegal;

    outs_t got;
    assign got = {wEN, INC, RST, compMUX, aluOP, busMUX, selAR, memREAD, memWRITE,
                  iROMREAD, halted, illegal};

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  ill_exp  = 1'b0;

    // Operand lookup: target bit index, or -1 when the operand is not allowed.
    int stac_tbl [16] = '{-1, -1, 12, 11, 10, 9, 8, 7, -1, -1, -1, 3, 2, 1, -1, -1};
    int inc_tbl  [16] = '{-1, -1, -1, -1, -1, -1, -1, -1, 4, 3, 2, -1, 1, 0, -1, -1};
    int clr_tbl  [16] = '{-1, -1, -1, -1, -1, -1, -1, -1, 4, 3, 2, -1, -1, -1, -1, -1};

    control_unit #(.WIDTH(8)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
`ifdef CU_STEP_EN
        .Step       (1'b1),
`endif
        .IROM_dataIn(IROM_dataIn),
        .zFlag      (zFlag),
        .wEN        (wEN),
        .INC        (INC),
        .RST        (RST),
        .compMUX    (compMUX),
        .aluOP      (aluOP),
        .busMUX     (busMUX),
        .selAR      (selAR),
        .memREAD    (memREAD),
        .memWRITE   (memWRITE),
        .iROMREAD   (iROMREAD),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_bad(input logic [7:0] ins);
        int r;
        r = int'(ins[3:0]);
        case (ins[7:4])
            4'h2:    return stac_tbl[r] < 0;
            4'h8:    return (r % 4) == 3;
            4'hA:    return inc_tbl[r] < 0;
            4'hB:    return clr_tbl[r] < 0;
            4'hC, 4'hD, 4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t model_exec(input logic [7:0] ins, input logic z, input bit second);
        outs_t o;
        int    r;
        o = '0;
        r = int'(ins[3:0]);
        if (!second) begin
            case (ins[7:4])
                4'h1: begin o.bus = ins[3:0]; o.wen[0] = 1'b1; end
                4'h2: if (stac_tbl[r] >= 0) begin o.bus = 4'd14; o.wen[stac_tbl[r]] = 1'b1; end
                4'h3: begin o.bus = ins[3:0]; o.alu = 3'b001; o.wen[0] = 1'b1; end
                4'h4: begin o.bus = ins[3:0]; o.alu = 3'b010; o.wen[0] = 1'b1; end
                4'h5: o.mrd = 1'b1;
                4'h6: begin o.mwr = 1'b1; o.bus = 4'd2; end
                4'h7: o.ird = 1'b1;
                4'h8: if ((r % 4) != 3) begin
                          o.cmp = 3'(1 << (r % 4));
                          o.wen[15] = z;
                      end
                4'h9: o.wen[15] = 1'b1;
                4'hA: if (inc_tbl[r] >= 0) o.inc[inc_tbl[r]] = 1'b1;
                4'hB: if (clr_tbl[r] >= 0) o.rst[clr_tbl[r]] = 1'b1;
                default: ;
            endcase
        end else begin
            if (ins[7:4] == 4'h5) begin
                o.mrd = 1'b1; o.bus = 4'd0; o.wen[12] = 1'b1;
            end else if (ins[7:4] == 4'h7) begin
                o.sel_ar = 1'b1; o.wen[13] = 1'b1; o.inc[5] = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        #1 check_eq("rst_low", 64'(got), 64'(0));
        repeat (2) @(negedge Clk);
        #1 check_eq("rst_hold", 64'(got), 64'(0));
        @(negedge Clk);
        Rst_n = 1'b1;
        ill_exp = 1'b0;
        #1 check_eq("boot", 64'(got), 64'(0));
    endtask

    // zmode: -1 random zFlag in EXEC1, else the forced value.
    task automatic run_instr(input logic [7:0] ins, input int zmode, input bit abort2);
        outs_t e;
        int    pcinc;
        logic  zv;
        bit    two;
        pcinc = 0;
        two   = (ins[7:4] == 4'h5) || (ins[7:4] == 4'h7);

        @(negedge Clk);
        IROM_dataIn = 8'($urandom); zFlag = 1'($urandom);
        #1 e = '0; e.ird = 1'b1; e.illegal = ill_exp;
        check_eq("fetch", 64'(got), 64'(e));
        pcinc += int'(got.inc[5]);

        @(negedge Clk);
        IROM_dataIn = ins; zFlag = 1'($urandom);
        #1 e = '0; e.inc[5] = 1'b1; e.illegal = ill_exp;
        check_eq("latch", 64'(got), 64'(e));
        pcinc += int'(got.inc[5]);

        @(negedge Clk);
        zv = (zmode < 0) ? 1'($urandom) : 1'(zmode);
        IROM_dataIn = 8'($urandom); zFlag = zv;
        #1 e = model_exec(ins, zv, 1'b0); e.illegal = ill_exp;
        check_eq("exec1", 64'(got), 64'(e));
        pcinc += int'(got.inc[5]);
        if (model_bad(ins)) ill_exp = 1'b1;

        if (two) begin
            @(negedge Clk);
            IROM_dataIn = (ins[7:4] == 4'h7) ? 8'h2A : 8'($urandom); zFlag = 1'($urandom);
            #1 e = model_exec(ins, zFlag, 1'b1); e.illegal = ill_exp;
            check_eq("exec2", 64'(got), 64'(e));
            pcinc += int'(got.inc[5]);
            if (abort2) begin
                Rst_n = 1'b0;
                #1 check_eq("async_rst", 64'(got), 64'(0));
                ill_exp = 1'b0;
                return;
            end
        end
        check_eq("pc_adv", 64'(pcinc), 64'((ins[7:4] == 4'h7) ? 2 : 1));
    endtask

    initial begin
        logic [7:0] ins;
        outs_t      e;

        do_reset();
        run_instr(8'h13, -1, 1'b0);
        run_instr(8'h70, -1, 1'b0);
        run_instr(8'h81,  1, 1'b0);
        run_instr(8'h81,  0, 1'b0);
        run_instr(8'h50, -1, 1'b0);
        run_instr(8'h2C, -1, 1'b0);
        run_instr(8'h60, -1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF) ins[7:4] = 4'h9;
            run_instr(ins, -1, 1'b0);
        end

        run_instr(8'hC0, -1, 1'b0);
        run_instr(8'h31, -1, 1'b0);
        run_instr(8'hF0, -1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            IROM_dataIn = 8'($urandom); zFlag = 1'($urandom);
            #1 e = '0; e.halted = 1'b1; e.illegal = ill_exp;
            check_eq("halt", 64'(got), 64'(e));
        end

        do_reset();
        for (int i = 0; i < 100; i++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF) ins[7:4] = 4'h5;
            run_instr(ins, -1, 1'b0);
        end
        run_instr(8'h50, -1, 1'b1);
        @(negedge Clk);
        #1 check_eq("abort_hold", 64'(got), 64'(0));
        Rst_n = 1'b1;
        #1 check_eq("abort_boot", 64'(got), 64'(0));
        run_instr(8'h13, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM that sits directly upstream of the 8-bit processor datapath. It fetches instruction bytes from IROM, decodes them, and drives every datapath strobe: register write enables, increments, clears, bus/compare mux selects, ALU op, and memory handshakes. It consumes the datapath's zero flag for conditional jumps.

## Interface
- WIDTH, 8: instruction/data width; the opcode always occupies IR[7:4] and the operand IR[3:0].
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- IROM_dataIn  in  WIDTH  instruction byte from IROM
- zFlag  in  1  datapath comparator result, combinational
- wEN  out  16  write enables: PC 15, AR 13, DR 12, RP 11, RT 10, RM1 9, RK1 8, RN1 7, RC1 3, RC2 2, RC3 1, AC 0; bits 14 and 6:4 are always 0
- INC  out  6  increments: PC 5, RM2 4, RK2 3, RN2 2, RC2 1, RC3 0
- RST  out  5  synchronous clears: RM2 4, RK2 3, RN2 2; bits 1:0 are always 0
- compMUX  out  3  one-hot compare-pair select: 001 N, 010 K, 100 M
- aluOP  out  3  000 PASS, 001 ADD, 010 MUL
- busMUX  out  4  bus source: 0 MEM, 1 AR, 2 DR, 3 RP, 4 RT, 5 RM1, 6 RK1, 7 RN1, 8 RM2, 9 RK2, 10 RN2, 11 RC1, 12 RC2, 13 RC3, 14 AC
- selAR  out  1  when 1, AR loads from IROM_dataIn instead of the bus
- memREAD, memWRITE, iROMREAD  out  1  memory strobes
- halted  out  1  1 while in HALT
- illegal  out  1  sticky; set by an undefined opcode or an invalid operand

## Operation
- States: BOOT, FETCH, LATCH, EXEC1, EXEC2, HALT. State and IR are registered. All outputs decode combinationally from state and IR.
- BOOT: all strobes 0. Always goes to FETCH.
- FETCH: iROMREAD=1. Goes to LATCH.
- LATCH: IR <= IROM_dataIn; INC[5]=1. Goes to EXEC1.
- Opcodes; single-cycle opcodes return from EXEC1 to FETCH:
  - 0x0 NOP: no strobes.
  - 0x1 LDAC r: busMUX=r, aluOP=PASS, wEN[0].
  - 0x2 STAC r: busMUX=14, plus the wEN bit of the register addressed by r. Valid only for r in {2,3,4,5,6,7,11,12,13}.
  - 0x3 ADD r / 0x4 MUL r: busMUX=r, aluOP=ADD or MUL, wEN[0].
  - 0x5 LOAD: EXEC1 memREAD=1; EXEC2 memREAD=1, busMUX=0, wEN[12].
  - 0x6 STORE: EXEC1 memWRITE=1, busMUX=2.
  - 0x7 LDAR (two-byte): EXEC1 iROMREAD=1; EXEC2 selAR=1, wEN[13], INC[5].
  - 0x8 JMPZ c: compMUX=one-hot(IR[1:0]), where 0=N, 1=K, 2=M; wEN[15] only if zFlag=1 in EXEC1.
  - 0x9 JMP: wEN[15]. PC loads from AR.
  - 0xA INC r: INC bit for r in {8,9,10,12,13}.
  - 0xB CLR r: RST bit for r in {8,9,10}.
  - 0xF HALT: goes to HALT. HALT is held until reset, with all strobes 0.
- Undefined opcodes, an invalid operand r, or c=3 execute as NOP and set illegal.
- At most one of memREAD, memWRITE and iROMREAD is high in any cycle.

## Timing
- Reset (asynchronous): state=BOOT, IR=0, illegal=0.
- While Rst_n is low, all outputs are 0.
- First FETCH occurs on the second rising edge after Rst_n deasserts.
- Cycles per instruction: 3 (FETCH, LATCH, EXEC1); LOAD and LDAR take 4.
- IROM and DRAM have 1-cycle read latency. Data is sampled at the end of the cycle following the strobe's first assertion.
- zFlag is sampled only in EXEC1 of JMPZ.
- Reset asserted mid-instruction aborts the instruction immediately; no strobe survives the asynchronous edge.

## Configuration
- CU_STEP_EN defined: adds input Step (1 bit). The FSM waits in FETCH with iROMREAD=0 until Step=1 is sampled, then proceeds, executing one instruction per Step pulse. Step is ignored in HALT.
- Undefined: no Step port; the FSM free-runs.

## Test plan
- Reset, then IROM[0]=0x13: BOOT, FETCH (iROMREAD=1), LATCH (INC=6'b100000), EXEC1 (busMUX=3, aluOP=000, wEN=16'h0001), then FETCH on cycle 5.
- LDAR with bytes 0x70, 0x2A: EXEC1 iROMREAD=1; EXEC2 selAR=1, wEN=16'h2000, INC[5]=1. PC has advanced by 2 in total.
- JMPZ 0x81 with zFlag=1: compMUX=010, wEN=16'h8000. Repeat with zFlag=0: wEN=0.
- LOAD 0x50: memREAD=1 for two cycles; second cycle busMUX=0, wEN=16'h1000. Opcode 0xC0: no strobes, illegal=1 and remains 1.
- 0xF0: halted=1 and all strobes stay 0 for 20 cycles. Pull Rst_n low mid-EXEC2 of LOAD: outputs go to 0 immediately.
- With CU_STEP_EN defined: no fetch occurs until Step pulses; one 3-cycle instruction executes per pulse.
